// File: rtl/mma_pkg.sv
// Shared widths, element types and helpers for the signed MMA pipe core.
package mma_pkg;

    localparam int unsigned MMA_M  = 8;
    localparam int unsigned MMA_N  = 4;
    localparam int unsigned MMA_K  = 16;
    localparam int unsigned P      = 8;
    localparam int unsigned ACC_W  = 4 * P;
    localparam int unsigned PROD_W = 2 * P;

    typedef logic signed [P-1:0]      opnd_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Extra bits needed so a K-term sum plus C cannot overflow before clamping
    function automatic int unsigned guard_bits(input int unsigned k);
        return $clog2(k + 1) + 1;
    endfunction

    localparam int unsigned GUARD_W = guard_bits(MMA_K);

endpackage

// File: rtl/mma_pipe_core_if.sv
// Operand/result bus with valid/ready handshakes on both sides of the core.
interface mma_pipe_core_if
    import mma_pkg::*;
#(
    parameter int unsigned M = MMA_M,
    parameter int unsigned N = MMA_N,
    parameter int unsigned K = MMA_K
);
    opnd_t A [M][K];
    opnd_t B [K][N];
    acc_t  C [M][N];
    logic  valid_in;
    logic  ready_in;
    acc_t  D [M][N];
    logic  valid_out;
    logic  ready_out;

    modport master (
        output A, B, C, valid_in, ready_out,
        input  ready_in, D, valid_out
    );

    modport slave (
        input  A, B, C, valid_in, ready_out,
        output ready_in, D, valid_out
    );
endinterface

// File: rtl/mma_dot_tree.sv
// One signed K-term dot product plus accumulator input.
// MMA_SATURATE_EN: clamp the result to the accumulator range instead of wrapping.
module mma_dot_tree
    import mma_pkg::*;
#(
    parameter int unsigned K    = MMA_K,
    parameter int unsigned TREE = 1
) (
    input  opnd_t a [K],
    input  opnd_t b [K],
    input  acc_t  c,
    output acc_t  sum_c
);
`ifdef MMA_SATURATE_EN
    localparam int unsigned SUM_W = ACC_W + guard_bits(K);
`else
    localparam int unsigned SUM_W = ACC_W;
`endif

    typedef logic signed [SUM_W-1:0] sum_t;

    sum_t prod [K];
    sum_t total;

    // Signed products, sign-extended to the internal sum width
    always_comb begin
        prod_t p;
        p = '0;
        for (int unsigned k = 0; k < K; k++) begin
            p       = a[k] * b[k];
            prod[k] = sum_t'(p);
        end
    end

    if (TREE != 0) begin : g_tree
        localparam int unsigned LVLS = $clog2(K);
        localparam int unsigned KP   = 1 << LVLS;

        sum_t lvl [LVLS+1][KP];

        // Pairwise reduction over a zero-padded power-of-two leaf set
        always_comb begin
            for (int unsigned l = 0; l <= LVLS; l++) begin
                for (int unsigned i = 0; i < KP; i++) begin
                    lvl[l][i] = '0;
                end
            end
            for (int unsigned k = 0; k < K; k++) begin
                lvl[0][k] = prod[k];
            end
            for (int unsigned l = 0; l < LVLS; l++) begin
                for (int unsigned i = 0; i < (KP >> (l + 1)); i++) begin
                    lvl[l+1][i] = lvl[l][2*i] + lvl[l][2*i+1];
                end
            end
            total = sum_t'(c) + lvl[LVLS][0];
        end
    end else begin : g_chain
        // Linear accumulation starting from C
        always_comb begin
            total = sum_t'(c);
            for (int unsigned k = 0; k < K; k++) begin
                total = total + prod[k];
            end
        end
    end

    // Reduce to accumulator width: clamp on overflow or plain wrap
    always_comb begin
`ifdef MMA_SATURATE_EN
        if ((&total[SUM_W-1:ACC_W-1]) || !(|total[SUM_W-1:ACC_W-1])) begin
            sum_c = total[ACC_W-1:0];
        end else if (total[SUM_W-1]) begin
            sum_c = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            sum_c = {1'b0, {(ACC_W-1){1'b1}}};
        end
`else
        sum_c = total;
`endif
    end

endmodule

// File: rtl/mma_pipe_core.sv
// Elastic-pipelined signed matrix multiply-accumulate: D = A*B + C.
// MMA_SATURATE_EN: results clamp to the accumulator range instead of wrapping.
module mma_pipe_core
    import mma_pkg::*;
#(
    parameter int unsigned M          = MMA_M,
    parameter int unsigned N          = MMA_N,
    parameter int unsigned K          = MMA_K,
    parameter int unsigned PIPESTAGES = 2,
    parameter int unsigned TREE       = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    mma_pipe_core_if.slave        bus
);

    opnd_t a_row [M][K];
    opnd_t b_col [N][K];
    acc_t  c_in  [M][N];
    acc_t  res   [M][N];

    acc_t                  data_q [PIPESTAGES][M][N];
    logic [PIPESTAGES-1:0] valid_q;
    logic [PIPESTAGES-1:0] adv;

    // Regroup operands into per-row / per-column vectors
    always_comb begin
        for (int unsigned m = 0; m < M; m++) begin
            for (int unsigned k = 0; k < K; k++) begin
                a_row[m][k] = bus.A[m][k];
            end
            for (int unsigned n = 0; n < N; n++) begin
                c_in[m][n] = bus.C[m][n];
            end
        end
        for (int unsigned n = 0; n < N; n++) begin
            for (int unsigned k = 0; k < K; k++) begin
                b_col[n][k] = bus.B[k][n];
            end
        end
    end

    for (genvar m = 0; m < int'(M); m++) begin : g_row
        for (genvar n = 0; n < int'(N); n++) begin : g_col
            mma_dot_tree #(
                .K    (K),
                .TREE (TREE)
            ) u_dot (
                .a     (a_row[m]),
                .b     (b_col[n]),
                .c     (c_in[m][n]),
                .sum_c (res[m][n])
            );
        end
    end

    // A stage moves when it is empty or its successor moves
    always_comb begin
        logic go;
        adv = '0;
        go  = ~valid_q[PIPESTAGES-1] | bus.ready_out;
        adv[PIPESTAGES-1] = go;
        for (int s = int'(PIPESTAGES) - 2; s >= 0; s--) begin
            go     = ~valid_q[s] | go;
            adv[s] = go;
        end
    end

    // Elastic stage registers; data only loads when a valid set arrives
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int unsigned s = 0; s < PIPESTAGES; s++) begin
                for (int unsigned m = 0; m < M; m++) begin
                    for (int unsigned n = 0; n < N; n++) begin
                        data_q[s][m][n] <= '0;
                    end
                end
            end
        end else begin
            if (adv[0]) begin
                valid_q[0] <= bus.valid_in;
                if (bus.valid_in) begin
                    data_q[0] <= res;
                end
            end
            for (int s = 1; s < int'(PIPESTAGES); s++) begin
                if (adv[s]) begin
                    valid_q[s] <= valid_q[s-1];
                    if (valid_q[s-1]) begin
                        data_q[s] <= data_q[s-1];
                    end
                end
            end
        end
    end

    assign bus.ready_in  = adv[0];
    assign bus.valid_out = valid_q[PIPESTAGES-1];
    assign bus.D         = data_q[PIPESTAGES-1];

endmodule

// File: tb/tb_mma_pipe_core.sv
// Scoreboard bench for mma_pipe_core (tree and chain builds side by side).
module tb_mma_pipe_core;
    import mma_pkg::*;

    localparam int unsigned M  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned K  = 16;
    localparam int unsigned PS = 2;

    typedef logic [M-1:0][N-1:0][31:0] exp_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    mma_pipe_core_if #(.M(M), .N(N), .K(K)) bus ();
    mma_pipe_core_if #(.M(M), .N(N), .K(K)) bus2 ();

    assign bus2.A         = bus.A;
    assign bus2.B         = bus.B;
    assign bus2.C         = bus.C;
    assign bus2.valid_in  = bus.valid_in;
    assign bus2.ready_out = bus.ready_out;

    mma_pipe_core #(.M(M), .N(N), .K(K), .PIPESTAGES(PS), .TREE(1)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    mma_pipe_core #(.M(M), .N(N), .K(K), .PIPESTAGES(PS), .TREE(0)) dut_chain (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus2)
    );

    int   checks   = 0;
    int   failures = 0;
    int   xfer_cnt = 0;
    int   cyc      = 0;
    exp_t exp_q [$];
    exp_t cur_exp;
    exp_t mon_e;
    exp_t hold_e;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    // Monitor: pop and compare on every output transfer
    always @(negedge clk_i) begin
        if (bus.valid_out && bus.ready_out) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected got=%0d expected=none", bus.D[0][0]);
            end else begin
                int bad_t;
                int bad_c;
                int fm;
                int fn;
                bad_t = 0;
                bad_c = 0;
                fm    = 0;
                fn    = 0;
                mon_e = exp_q.pop_front();
                for (int m = 0; m < int'(M); m++) begin
                    for (int n = 0; n < int'(N); n++) begin
                        if (bus.D[m][n] !== mon_e[m][n]) begin
                            if (bad_t == 0) begin fm = m; fn = n; end
                            bad_t++;
                        end
                        if (bus2.D[m][n] !== mon_e[m][n]) bad_c++;
                    end
                end
                checks++;
                if (bad_t != 0) begin
                    failures++;
                    $display("FAIL d_tree[%0d][%0d] got=%0d expected=%0d", fm, fn,
                             bus.D[fm][fn], $signed(mon_e[fm][fn]));
                end
                chk("d_chain_mismatches", bad_c, 0);
                chk("chain_valid_out", int'(bus2.valid_out), 1);
            end
        end
    end

    // Drive one operand set of a given shape and record its expected result
    task automatic build(input int kind, input int a, input int b, input int c);
        for (int m = 0; m < int'(M); m++) begin
            for (int k = 0; k < int'(K); k++) begin
                case (kind)
                    1:       bus.A[m][k] = opnd_t'((m == k && m < 4) ? 1 : 0);
                    2:       bus.A[m][k] = opnd_t'(m + a);
                    3:       bus.A[m][k] = opnd_t'(k - 8);
                    default: bus.A[m][k] = opnd_t'(a);
                endcase
            end
        end
        for (int k = 0; k < int'(K); k++) begin
            for (int n = 0; n < int'(N); n++) begin
                case (kind)
                    1:       bus.B[k][n] = opnd_t'(k + n);
                    2:       bus.B[k][n] = opnd_t'(n - 2);
                    3:       bus.B[k][n] = opnd_t'(n + 1);
                    default: bus.B[k][n] = opnd_t'(b);
                endcase
            end
        end
        for (int m = 0; m < int'(M); m++) begin
            for (int n = 0; n < int'(N); n++) begin
                case (kind)
                    1: begin
                        bus.C[m][n]   = '0;
                        cur_exp[m][n] = 32'((m < 4) ? (m + n) : 0);
                    end
                    2: begin
                        bus.C[m][n]   = acc_t'(m * 10 + n);
                        cur_exp[m][n] = 32'(m * 10 + n + 16 * (m + a) * (n - 2));
                    end
                    3: begin
                        bus.C[m][n]   = acc_t'(m + c);
                        cur_exp[m][n] = 32'(m + c - 8 * (n + 1));
                    end
                    default: begin
                        bus.C[m][n]   = acc_t'(c);
                        cur_exp[m][n] = 32'(c + 16 * a * b);
                    end
                endcase
            end
        end
    endtask

    // Hold valid_in until accepted (bounded), then leave just after the edge
    task automatic send();
        int t;
        t = 0;
        bus.valid_in = 1'b1;
        @(negedge clk_i);
        while (!bus.ready_in && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        if (!bus.ready_in) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=%0d expected=1", bus.ready_in);
        end else begin
            exp_q.push_back(cur_exp);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        bus.valid_in = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        int base;
        int c0;
        int nz;

        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        build(0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Reset state
        @(negedge clk_i);
        chk("rst_valid_out", int'(bus.valid_out), 0);
        chk("rst_ready_in", int'(bus.ready_in), 1);
        nz = 0;
        for (int m = 0; m < int'(M); m++)
            for (int n = 0; n < int'(N); n++)
                if (bus.D[m][n] != 0) nz++;
        chk("rst_d_nonzero", nz, 0);
        @(posedge clk_i);
        #1;

        // Identity rows with latency check
        build(1, 0, 0, 0);
        send();
        idle();
        for (int i = 0; i < int'(PS) - 1; i++) begin
            @(negedge clk_i);
            chk("lat_early_valid", int'(bus.valid_out), 0);
        end
        @(negedge clk_i);
        chk("lat_valid_on_time", int'(bus.valid_out), 1);
        settle(3);

        // Signed extremes and accumulate wrap
        @(posedge clk_i); #1;
        build(0, -128, -128, 0);
        for (int m = 0; m < int'(M); m++)
            for (int n = 0; n < int'(N); n++) cur_exp[m][n] = 32'd262144;
        send();
        build(0, -128, 127, 0);
        for (int m = 0; m < int'(M); m++)
            for (int n = 0; n < int'(N); n++) cur_exp[m][n] = 32'hFFFC_0800;
        send();
        build(0, 127, 127, 32'h7FFF_FFFF);
        for (int m = 0; m < int'(M); m++)
            for (int n = 0; n < int'(N); n++)
`ifdef MMA_SATURATE_EN
                cur_exp[m][n] = 32'h7FFF_FFFF;
`else
                cur_exp[m][n] = 32'h8003_F00F;
`endif
        send();
        idle();
        settle(PS + 3);

        // Back-pressure: two sets fill the pipe, then upstream stalls
        @(posedge clk_i); #1;
        bus.ready_out = 1'b0;
        build(0, 1, 2, 100);
        hold_e = cur_exp;
        send();
        build(0, 2, 3, 200);
        send();
        fork
            begin
                build(0, 3, 4, 300); send();
                build(0, 4, 5, 400); send();
                build(0, 5, 6, 500); send();
                idle();
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk_i);
                    chk("stall_ready_in", int'(bus.ready_in), 0);
                    chk("stall_valid_out", int'(bus.valid_out), 1);
                    chk("stall_d_hold", int'(bus.D[0][0]), int'(hold_e[0][0]));
                end
                @(posedge clk_i);
                #1;
                bus.ready_out = 1'b1;
                base = xfer_cnt;
                settle(5);
                #1;
                chk("release_burst_count", xfer_cnt - base, 5);
            end
        join
        settle(3);
        chk("bp_queue_drained", exp_q.size(), 0);

        // Throughput: 20 back-to-back sets
        @(posedge clk_i); #1;
        base = xfer_cnt;
        c0   = cyc;
        for (int i = 0; i < 20; i++) begin
            build(i % 4, i - 10, 7 - i, i * 1000 - 5000);
            send();
        end
        idle();
        chk("tput_accept_cycles", cyc - c0, 20);
        settle(PS);
        #1;
        chk("tput_out_count", xfer_cnt - base, 20);
        settle(2);

        // Reset with two sets in flight
        @(posedge clk_i); #1;
        bus.ready_out = 1'b0;
        build(0, 6, 7, 11);
        send();
        build(3, 0, 0, 22);
        send();
        idle();
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        exp_q.delete();
        @(negedge clk_i);
        chk("mid_rst_valid_out", int'(bus.valid_out), 0);
        chk("mid_rst_ready_in", int'(bus.ready_in), 1);
        nz = 0;
        for (int m = 0; m < int'(M); m++)
            for (int n = 0; n < int'(N); n++)
                if (bus.D[m][n] != 0 || bus2.D[m][n] != 0) nz++;
        chk("mid_rst_d_nonzero", nz, 0);
        bus.ready_out = 1'b1;
        base = xfer_cnt;
        settle(6);
        #1;
        chk("mid_rst_no_ghost", xfer_cnt - base, 0);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
